seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_div_pkg.sv | 23 ++
 rtl/div_step.sv | 15 +
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// SEQ_DIVIDER_SIGNED_EN adds the FIX state and two's-complement handling.
package seq_div_pkg;
  localparam int WIDTH      = 8;
  localparam int ITERATIONS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_TRIAL,
`ifdef SEQ_DIVIDER_SIGNED_EN
    S_FIX,
`endif
    S_DONE,
    S_WAIT_REL
  } state_t;

  // Magnitude of a two's-complement operand; 8'h80 maps to 128, which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division trial: compares the partial remainder against the divisor.
module div_step
  import seq_div_pkg::*;
(
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   diff,
  output logic             ge
);
  // Partial remainder can reach 2*D-1, hence the extra bit on a and diff.
  always_comb begin
    diff = a - {1'b0, d};
    ge   = (a >= {1'b0, d});
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential shift/subtract divider, one quotient bit per SHIFT+TRIAL pair.
// Optional SEQ_DIVIDER_SIGNED_EN: two's-complement operands, results fixed up in FIX.
module seq_divider
  import seq_div_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);
  localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

  state_t           state, state_nxt;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q, d;
  logic [3:0]       cnt;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] q_fin, r_fin;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_dvd, neg_dvs;
`endif

  div_step u_step (.a(a), .d(d), .diff(diff), .ge(ge));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; Run only matters in IDLE and WAIT_REL
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (Run) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = (Divisor == '0) ? S_DONE : S_SHIFT;
      S_SHIFT:    state_nxt = S_TRIAL;
`ifdef SEQ_DIVIDER_SIGNED_EN
      S_TRIAL:    state_nxt = (cnt == LAST_ITER) ? S_FIX : S_SHIFT;
      S_FIX:      state_nxt = S_DONE;
`else
      S_TRIAL:    state_nxt = (cnt == LAST_ITER) ? S_DONE : S_SHIFT;
`endif
      S_DONE:     state_nxt = S_WAIT_REL;
      S_WAIT_REL: if (!Run) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      S_LOAD, S_SHIFT, S_TRIAL: Busy = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
      S_FIX:                    Busy = 1'b1;
`endif
      S_DONE:                   Done = 1'b1;
      default: ;
    endcase
  end

  // Result to write on the edge entering DONE, so outputs are valid while Done is high
  always_comb begin
    q_fin = q;
    r_fin = a[WIDTH-1:0];
    case (state)
      S_LOAD: begin
        q_fin = '1;
        r_fin = Dividend;
      end
      S_TRIAL: begin
        q_fin = {q[WIDTH-1:1], ge};
        r_fin = ge ? diff[WIDTH-1:0] : a[WIDTH-1:0];
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      S_FIX: begin
        q_fin = (neg_dvd ^ neg_dvs) ? (~q + 1'b1) : q;
        r_fin = neg_dvd ? (~a[WIDTH-1:0] + 1'b1) : a[WIDTH-1:0];
      end
`endif
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_dvd   <= 1'b0;
      neg_dvs   <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          a         <= '0;
          cnt       <= '0;
          // Set here for the zero-divisor case (which goes straight to DONE), cleared otherwise
          DivByZero <= (Divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
          q         <= mag(Dividend);
          d         <= mag(Divisor);
          neg_dvd   <= Dividend[WIDTH-1];
          neg_dvs   <= Divisor[WIDTH-1];
`else
          q         <= Dividend;
          d         <= Divisor;
`endif
        end
        S_SHIFT: {a, q} <= {a[WIDTH-1:0], q, 1'b0};
        S_TRIAL: begin
          if (ge) begin
            a    <= diff;
            q[0] <= 1'b1;
          end
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
      if (state_nxt == S_DONE) begin
        Quotient  <= q_fin;
        Remainder <= r_fin;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on Done.
module tb_seq_divider;
  logic       Clk = 1'b0, Reset = 1'b1, Run = 1'b0;
  logic [7:0] Dividend = '0, Divisor = '0;
  logic [7:0] Quotient, Remainder;
  logic       Busy, Done, DivByZero;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 18;
`endif

  seq_divider dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain arithmetic; start is the cycle whose following edge first samples Run
  function automatic exp_t model(input logic [7:0] dvd, input logic [7:0] dvs, input int start);
    exp_t e;
    int   sa, sd;
    sa = 0; sd = 0;
    if (dvs == 0) begin
      e.q = 8'hFF; e.r = dvd; e.dbz = 1'b1; e.at = start + 2;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = $signed(dvd);
      sd = $signed(dvs);
      e.q = 8'(sa / sd);
      e.r = 8'(sa % sd);
`else
      sa = dvd; sd = dvs;
      e.q = 8'(sa / sd);
      e.r = 8'(sa % sd);
`endif
      e.dbz = 1'b0;
      e.at  = start + LAT;
    end
    return e;
  endfunction

  // Monitor: every Done must match the oldest expected result
  always @(negedge Clk) begin
    exp_t e;
    if (Done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done at cycle %0d: got Done=1 want Done=0", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(Quotient), 32'(e.q));
        chk("remainder", 32'(Remainder), 32'(e.r));
        chk("divbyzero", 32'(DivByZero), 32'(e.dbz));
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() > 0; k++) @(negedge Clk);
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL done_timeout at cycle %0d: got no Done want %0d pending", cyc, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge Clk);
  endtask

  // Hold Run for 'hold' cycles; operands stay stable through LOAD, then get scrambled
  task automatic issue(input logic [7:0] dvd, input logic [7:0] dvs, input int hold);
    int lim;
    lim = (hold > 2) ? hold : 2;
    @(negedge Clk);
    Dividend = dvd; Divisor = dvs; Run = 1'b1;
    sb.push_back(model(dvd, dvs, cyc));
    for (int k = 1; k <= lim; k++) begin
      @(negedge Clk);
      if (k == hold) Run = 1'b0;
    end
    Dividend = 8'($urandom); Divisor = 8'($urandom);
    drain();
  endtask

  initial begin
    logic [7:0] rd, rs;
    int         c0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk("rst_quotient", 32'(Quotient), 0);
    chk("rst_remainder", 32'(Remainder), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_dbz", 32'(DivByZero), 0);

    // 100/7 with Busy profile, operands disturbed after LOAD
    Dividend = 8'd100; Divisor = 8'd7; Run = 1'b1;
    sb.push_back(model(8'd100, 8'd7, cyc));
    for (int k = 1; k <= LAT; k++) begin
      @(negedge Clk);
      if (k == 1) Run = 1'b0;
      if (k == 2) begin Dividend = 8'd3; Divisor = 8'd0; Run = 1'b1; end
      if (k == 3) Run = 1'b0;
      chk("busy_profile", 32'(Busy), (k <= LAT - 1) ? 1 : 0);
    end
    drain();

    issue(8'd255, 8'd1,   1);
    issue(8'd3,   8'd200, 1);
    issue(8'd5,   8'd0,   1);
    issue(8'd9,   8'd3,   1);
    issue(8'hF9,  8'd2,   1);
    issue(8'h80,  8'hFF,  1);
    issue(8'd0,   8'd1,   2);
    issue(8'd1,   8'd255, 3);

    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(rd, rs, $urandom_range(1, 3));
    end

    // Run held for 40 cycles gives one Done; then a fresh request starts again
    issue(8'd200, 8'd9, 40);
    issue(8'd77,  8'd5, 1);

    // Reset in cycle 9 of 100/7: no Done, everything cleared
    @(negedge Clk);
    Dividend = 8'd100; Divisor = 8'd7; Run = 1'b1;
    c0 = cyc;
    @(negedge Clk); Run = 1'b0;
    while (cyc < c0 + 9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst_quotient", 32'(Quotient), 0);
    chk("midrst_remainder", 32'(Remainder), 0);
    chk("midrst_busy", 32'(Busy), 0);
    chk("midrst_done", 32'(Done), 0);
    chk("midrst_dbz", 32'(DivByZero), 0);
    repeat (25) @(negedge Clk);

    issue(8'd42, 8'd6, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
